// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT sink-side controller.
package fft_ctrl_pkg;

    // Frame sequencer states: wait one edge after reset, stream a frame, idle between frames.
    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        GAP
    } state_t;

    // Width of the transform-length field presented to the FFT core.
    localparam int FFTPTS_W = 11;

    // The controller never flags a sample as erroneous.
    localparam logic [1:0] SINK_ERROR_NONE = 2'b00;

endpackage

// File: rtl/fft_sink_control.sv
// Packetises a free-running sample stream into FFT_POINTS-sample frames on an
// Avalon-ST style sink interface, with GAP_CYCLES idle cycles between frames.
module fft_sink_control
    import fft_ctrl_pkg::*;
#(
    parameter int FFT_POINTS = 1024,
    parameter int GAP_CYCLES = 2,
    parameter int DATA_W     = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   insignal,
    input  logic                sink_ready,
    output logic                sink_valid,
    output logic                sink_sop,
    output logic                sink_eop,
    output logic [1:0]          sink_error,
    output logic                inverse,
    output logic [DATA_W-1:0]   outreal,
    output logic [DATA_W-1:0]   outimag,
    output logic [FFTPTS_W-1:0] fft_pts
);

    localparam int IDX_W = $clog2(FFT_POINTS) + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_POINTS - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [GAP_W-1:0] gap_cnt;
    logic             eop_accept;
    logic             gap_done;
    logic             load;

    // Transform configuration is fixed for the life of the stream.
    assign sink_error = SINK_ERROR_NONE;
    assign inverse    = 1'b0;
    assign fft_pts    = FFTPTS_W'(FFT_POINTS);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values, independent of block evaluation order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and load decision; the last gap edge loads the frame's first sample
    // so the bus is idle for exactly GAP_CYCLES cycles.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        load       = 1'b0;
        eop_accept = sink_valid && sink_ready && sink_eop;
        gap_done   = (gap_cnt == GAP_LAST);
        case (state)
            IDLE: begin
                state_next = STREAM;
            end
            STREAM: begin
                if (eop_accept) begin
                    state_next = GAP;
                end else begin
                    load = !sink_valid || sink_ready;
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_next = STREAM;
                    load       = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output register, sample index and gap counter; a stalled sample holds unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sink_valid <= 1'b0;
            sink_sop   <= 1'b0;
            sink_eop   <= 1'b0;
            outreal    <= '0;
            outimag    <= '0;
            idx        <= '0;
            gap_cnt    <= '0;
        end else begin
            if (eop_accept) begin
                sink_valid <= 1'b0;
                sink_sop   <= 1'b0;
                sink_eop   <= 1'b0;
                idx        <= '0;
                gap_cnt    <= GAP_LOAD;
            end else if (load) begin
                outreal    <= insignal;
                outimag    <= '0;
                sink_valid <= 1'b1;
                sink_sop   <= (idx == '0);
                sink_eop   <= (idx == LAST_IDX);
                idx        <= idx + IDX_W'(1);
            end
            if (state == GAP && !gap_done) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fft_sink_control.sv
// Scoreboard bench for fft_sink_control: an 8-point/2-gap instance exercises
// streaming, stalls, eop back-pressure and mid-frame reset while a 1024-point/
// 1-gap instance streams three frames with ready held high.
module tb_fft_sink_control;
    import fft_ctrl_pkg::*;

    localparam int DW   = 32;
    localparam int PTS0 = 8;
    localparam int GAP0 = 2;
    localparam int PTS1 = 1024;
    localparam int GAP1 = 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } exp_t;

    typedef enum {M_IDLE, M_RUN, M_GAP} mphase_t;

    typedef struct {
        mphase_t phase;
        logic    valid;
        logic    eop;
        int      idx;
        int      gap_left;
    } model_t;

    logic                clk = 1'b0;
    logic                rst      [2];
    logic                ready    [2];
    logic [DW-1:0]       insignal;
    logic                valid    [2];
    logic                sop      [2];
    logic                eop      [2];
    logic                inverse  [2];
    logic [1:0]          serr     [2];
    logic [DW-1:0]       outreal  [2];
    logic [DW-1:0]       outimag  [2];
    logic [FFTPTS_W-1:0] fft_pts  [2];

    int     checks   = 0;
    int     failures = 0;
    int     pts_of [2] = '{PTS0, PTS1};
    int     gap_of [2] = '{GAP0, GAP1};
    int     eop_seen [2] = '{0, 0};
    exp_t   q0 [$];
    exp_t   q1 [$];
    model_t m [2];

    always #5 clk = ~clk;

    fft_sink_control #(.FFT_POINTS(PTS0), .GAP_CYCLES(GAP0), .DATA_W(DW)) u_dut0 (
        .clk(clk), .reset(rst[0]), .insignal(insignal), .sink_ready(ready[0]),
        .sink_valid(valid[0]), .sink_sop(sop[0]), .sink_eop(eop[0]),
        .sink_error(serr[0]), .inverse(inverse[0]), .outreal(outreal[0]),
        .outimag(outimag[0]), .fft_pts(fft_pts[0])
    );

    fft_sink_control #(.FFT_POINTS(PTS1), .GAP_CYCLES(GAP1), .DATA_W(DW)) u_dut1 (
        .clk(clk), .reset(rst[1]), .insignal(insignal), .sink_ready(ready[1]),
        .sink_valid(valid[1]), .sink_sop(sop[1]), .sink_eop(eop[1]),
        .sink_error(serr[1]), .inverse(inverse[1]), .outreal(outreal[1]),
        .outimag(outimag[1]), .fft_pts(fft_pts[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- reference model (transfer-level protocol) ----------------
    task automatic model_reset(input int k);
        m[k].phase    = M_IDLE;
        m[k].valid    = 1'b0;
        m[k].eop      = 1'b0;
        m[k].idx      = 0;
        m[k].gap_left = 0;
        if (k == 0) q0.delete();
        else        q1.delete();
    endtask

    task automatic model_load(input int k);
        exp_t e;
        e.data = insignal;
        e.sop  = (m[k].idx == 0);
        e.eop  = (m[k].idx == pts_of[k] - 1);
        m[k].valid = 1'b1;
        m[k].eop   = e.eop;
        m[k].idx++;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic model_edge(input int k);
        if (rst[k]) return;
        case (m[k].phase)
            M_IDLE: m[k].phase = M_RUN;
            M_RUN: begin
                if (m[k].valid && ready[k] && m[k].eop) begin
                    m[k].valid    = 1'b0;
                    m[k].eop      = 1'b0;
                    m[k].idx      = 0;
                    m[k].phase    = M_GAP;
                    m[k].gap_left = gap_of[k];
                end else if (!m[k].valid || ready[k]) begin
                    model_load(k);
                end
            end
            M_GAP: begin
                m[k].gap_left--;
                if (m[k].gap_left == 0) begin
                    m[k].phase = M_RUN;
                    model_load(k);
                end
            end
            default: m[k].phase = M_IDLE;
        endcase
    endtask

    // One clock: update models with pre-edge inputs, then advance the ramp.
    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1 insignal = insignal + 1;
    endtask

    task automatic pop_exp(input int k, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '0;
        if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
        if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
    endtask

    task automatic wait_frames(input int k, input int target, input int budget, input string tag);
        int n = 0;
        while (eop_seen[k] < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(eop_seen[k] >= target), 64'd1);
    endtask

    task automatic wait_model(input int k, input int want_idx, input bit want_eop,
                              input int budget, input string tag);
        int n = 0;
        while (!(m[k].valid && (want_eop ? m[k].eop : (m[k].idx == want_idx))) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(n < budget), 64'd1);
    endtask

    // ---------------- monitor: compares every accepted transfer ----------------
    int   frame_len [2] = '{0, 0};
    int   gap_len   [2] = '{0, 0};
    bit   gap_track [2] = '{0, 0};
    bit   stall     [2] = '{0, 0};
    exp_t held      [2];

    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst[k]) begin
                    frame_len[k] = 0;
                    gap_track[k] = 1'b0;
                    stall[k]     = 1'b0;
                end else begin
                    if (stall[k]) begin
                        check($sformatf("stall_hold%0d", k),
                              {29'd0, valid[k], outreal[k], sop[k], eop[k]},
                              {29'd0, 1'b1, held[k].data, held[k].sop, held[k].eop});
                        stall[k] = 1'b0;
                    end
                    if (valid[k]) begin
                        check($sformatf("outimag%0d", k), outimag[k], 0);
                        if (gap_track[k]) begin
                            check($sformatf("gap_len%0d", k), gap_len[k], gap_of[k]);
                            gap_track[k] = 1'b0;
                        end
                        if (ready[k]) begin
                            pop_exp(k, e, ok);
                            check($sformatf("xfer_expected%0d", k), 64'(ok), 64'd1);
                            if (ok)
                                check($sformatf("xfer%0d", k),
                                      {30'd0, outreal[k], sop[k], eop[k]},
                                      {30'd0, e.data, e.sop, e.eop});
                            frame_len[k] = sop[k] ? 1 : frame_len[k] + 1;
                            if (eop[k]) begin
                                check($sformatf("frame_len%0d", k), frame_len[k], pts_of[k]);
                                gap_track[k] = 1'b1;
                                gap_len[k]   = 0;
                                eop_seen[k]++;
                            end
                        end else begin
                            stall[k]     = 1'b1;
                            held[k].data = outreal[k];
                            held[k].sop  = sop[k];
                            held[k].eop  = eop[k];
                        end
                    end else if (gap_track[k]) begin
                        gap_len[k]++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int target;
        insignal = 100;
        rst      = '{1'b1, 1'b1};
        ready    = '{1'b1, 1'b1};
        model_reset(0);
        model_reset(1);
        repeat (3) tick();

        // Reset state and constant outputs of both instances.
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_valid%0d", k),   valid[k],   0);
            check($sformatf("rst_sop%0d", k),     sop[k],     0);
            check($sformatf("rst_eop%0d", k),     eop[k],     0);
            check($sformatf("rst_outreal%0d", k), outreal[k], 0);
            check($sformatf("rst_outimag%0d", k), outimag[k], 0);
            check($sformatf("fft_pts%0d", k),     fft_pts[k], pts_of[k]);
            check($sformatf("inverse%0d", k),     inverse[k], 0);
            check($sformatf("sink_error%0d", k),  serr[k],    0);
        end
        tick();
        rst = '{1'b0, 1'b0};

        // Two back-to-back frames with ready held high.
        wait_frames(0, 2, 100, "stream_frames");

        // Stall for three cycles once the third sample is presented.
        wait_model(0, 3, 1'b0, 100, "reach_sample3");
        ready[0] = 1'b0;
        repeat (3) tick();
        ready[0] = 1'b1;
        wait_frames(0, 3, 100, "stall_frame");

        // Back-pressure on the eop sample; gap must start only after acceptance.
        wait_model(0, 0, 1'b1, 100, "reach_eop");
        ready[0] = 1'b0;
        repeat (2) tick();
        ready[0] = 1'b1;
        wait_frames(0, 4, 100, "eop_stall_frame");

        // Asynchronous reset in the middle of a frame.
        wait_model(0, 5, 1'b0, 100, "reach_sample5");
        check("pre_reset_valid", valid[0], 1);
        #2 rst[0] = 1'b1;
        #1;
        check("async_valid",   valid[0],   0);
        check("async_sop",     sop[0],     0);
        check("async_eop",     eop[0],     0);
        check("async_outreal", outreal[0], 0);
        model_reset(0);
        repeat (2) tick();
        rst[0] = 1'b0;
        target = eop_seen[0] + 2;
        wait_frames(0, target, 100, "post_reset_frames");

        // Large instance: three full frames.
        wait_frames(1, 3, 5000, "big_frames");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "simulation did not terminate");
    end

endmodule
